// File: rtl/seg_pipe_adder_if.sv
// rtl/seg_pipe_adder_if.sv - operand/result handshake bundle for seg_pipe_adder
interface seg_pipe_adder_if #(
  parameter int WIDTH = 16
);
  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Environment view: drives operands and result acceptance
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder view
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seg_pipe_adder.sv
// rtl/seg_pipe_adder.sv - segmented pipelined adder/subtractor; SEG_PIPE_ADDER_SAT_EN enables signed saturation
module seg_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic            clk,
  input  logic            rst,
  seg_pipe_adder_if.slave bus
);
  localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
  localparam int NST      = WIDTH / SEG_SAFE;

  if ((SEG < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_bad_cfg
    $error("seg_pipe_adder: WIDTH must be a positive multiple of SEG");
  end

  // Stage k registers hold the operands (upper segments still pending), the
  // partial result (segments 0..k done), the carry out of segment k and the
  // beat's valid bit. The last stage's registers are the output.
  logic [WIDTH-1:0] a_q [NST];
  logic [WIDTH-1:0] b_q [NST];
  logic [WIDTH-1:0] s_q [NST];
  logic             c_q [NST];
  logic             v_q [NST];
  logic             ovf_q;

  // Values presented to each stage and what it will register
  logic [WIDTH-1:0] a_in [NST];
  logic [WIDTH-1:0] b_in [NST];
  logic [WIDTH-1:0] s_in [NST];
  logic             c_in [NST];
  logic             v_in [NST];
  logic [WIDTH-1:0] s_nx [NST];
  logic             c_nx [NST];
  logic             ovf_nx;

  logic stall;

  assign stall        = v_q[NST-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  assign bus.out_valid = v_q[NST-1];
  assign bus.sum       = s_q[NST-1];
  assign bus.cout      = c_q[NST-1];
  assign bus.ovf       = ovf_q;

  for (genvar k = 0; k < NST; k++) begin : g_stage
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG_SAFE{1'b1}}) << (k * SEG_SAFE);

    logic [SEG_SAFE:0]  seg_sum;
    logic [WIDTH-1:0]   s_raw;

    if (k == 0) begin : g_first
      // Subtraction is A + ~B + 1: invert B here and force the first carry.
      assign a_in[k] = bus.a;
      assign b_in[k] = bus.b ^ {WIDTH{bus.sub}};
      assign s_in[k] = '0;
      assign c_in[k] = bus.sub | bus.cin;
      assign v_in[k] = bus.in_valid;
    end else begin : g_rest
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign v_in[k] = v_q[k-1];
    end

    assign seg_sum = {1'b0, a_in[k][k*SEG_SAFE +: SEG_SAFE]}
                   + {1'b0, b_in[k][k*SEG_SAFE +: SEG_SAFE]}
                   + {{SEG_SAFE{1'b0}}, c_in[k]};
    assign s_raw   = (s_in[k] & ~SEG_MASK) | (WIDTH'(seg_sum[SEG_SAFE-1:0]) << (k * SEG_SAFE));
    assign c_nx[k] = seg_sum[SEG_SAFE];

    if (k == NST - 1) begin : g_last
      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
      logic msb_cin;
      assign msb_cin = a_in[k][WIDTH-1] ^ b_in[k][WIDTH-1] ^ seg_sum[SEG_SAFE-1];
      assign ovf_nx  = msb_cin ^ seg_sum[SEG_SAFE];
`ifdef SEG_PIPE_ADDER_SAT_EN
      // Overflow direction follows A's sign: positive A saturates to max, negative to min.
      assign s_nx[k] = ovf_nx ? {a_in[k][WIDTH-1], {(WIDTH-1){~a_in[k][WIDTH-1]}}} : s_raw;
`else
      assign s_nx[k] = s_raw;
`endif
    end else begin : g_mid
      assign s_nx[k] = s_raw;
    end
  end

  // Advance all stages together unless the output is stalled; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NST; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < NST; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_nx[k];
        c_q[k] <= c_nx[k];
        v_q[k] <= v_in[k];
      end
      ovf_q <= ovf_nx;
    end
  end
endmodule

// File: doc/seg_pipe_adder.md
Name: seg_pipe_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. Operands are WIDTH bits wide and are split into SEG-bit segments.
- Each pipeline stage adds one segment and registers its carry into the next stage. This gives one result per clock at full throughput.
- Valid/ready handshakes on both sides. Sits between operand sources and the datapath, replacing the fixed 4-bit combinational adder where wide operands would break timing.

Parameters:
- WIDTH, 16, operand and result width. Must be a multiple of SEG.
- SEG, 4, bits added per pipeline stage. NST = WIDTH/SEG is the stage count and the latency.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in. Ignored when sub=1.
- sub  input  1  0 = A+B+cin; 1 = A-B (A + ~B + 1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. For sub, 1 means no borrow.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async assert, sync release):
  - Every pipeline register, valid bit and carry clears.
  - out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
  - Beats in flight are discarded; nothing emerges after reset.
- Transfer rules:
  - An input transfer occurs when in_valid and in_ready are both 1.
  - An output transfer occurs when out_valid and out_ready are both 1.
- Stall: stall = out_valid and not out_ready.
  - in_ready = not stall, combinational.
  - While stalled, every stage register holds, and sum/cout/ovf/out_valid stay stable.
  - When stall=0 all stages advance together. A bubble (in_valid=0) advances as valid=0.
- Stage k (k = 0..NST-1) adds segment k:
  - Inputs: a[k*SEG +: SEG], b'[k*SEG +: SEG] and carry c_k.
  - b' = b XOR {WIDTH{sub}}.
  - c_0 = sub ? 1 : cin.
  - c_{k+1} is registered with the stage.
- Upper operand segments are delayed in skew registers until their stage. Lower result segments are carried forward in de-skew registers. All WIDTH result bits therefore emerge aligned.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NST, when no stall occurs. Each stall cycle adds one cycle.
- Throughput: 1 beat/clk. Results leave strictly in acceptance order.
- Output flags:
  - cout = carry out of the last stage.
  - ovf = carry into MSB XOR carry out of MSB. Computed in the last stage and registered with sum.
- Boundaries:
  - WIDTH=SEG (NST=1): single-register adder, latency 1.
  - A full pipeline with out_ready=0 loses no data.
  - When the output is accepted while a new input is accepted in the same cycle (out_ready=1), both transfers occur.
  - Wrap-around is modulo 2^WIDTH. Only cout/ovf report overflow.
- Elaboration error if WIDTH mod SEG ≠ 0 or SEG < 1.

Optional Feature:
- Macro: SEG_PIPE_ADDER_SAT_EN.
- Defined: when ovf=1, sum is replaced by the signed saturation value.
  - Positive overflow gives 0111…1. Negative overflow gives 1000…0.
  - The overflow sign is taken from operand A's MSB, carried through the skew path.
  - ovf is still reported as 1; cout is unchanged.
- Undefined: sum is the plain modular result and carries no saturation logic.

Test Plan:
- Reset: assert rst mid-stream with 3 beats in flight -> out_valid=0, sum=0, in_ready=1 immediately. No result appears for 10 cycles after release with in_valid=0.
- Carry ripple across all segments (WIDTH=16, SEG=4): a=0xFFFF, b=0x0001, cin=0, sub=0 accepted at cycle 0 -> out_valid at cycle 4, sum=0x0000, cout=1, ovf=0.
- Subtract with signed overflow: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1. With SEG_PIPE_ADDER_SAT_EN defined -> sum=0x8000, ovf=1.
- Streaming: 8 back-to-back beats, a=i, b=0x1000*i, cin=i[0], out_ready=1 -> 8 consecutive results from cycle 4, in order, each equal to a+b+cin mod 2^16.
- Backpressure: fill the pipeline, then hold out_ready=0 for 5 cycles -> in_ready=0 throughout, sum/out_valid frozen. Release -> all beats delivered in order, none duplicated or lost.
- Parameter sweep: WIDTH=8/SEG=8 and WIDTH=32/SEG=4 -> latency 1 and 8 respectively. A random 1000-beat compare against a behavioural a±b model is exact.
